// File: rtl/pcie_lpif_pkg.sv
// pcie_lpif_pkg: shared LPIF state encodings, transmit-stage FSM states and entry sizing
package pcie_lpif_pkg;
  localparam logic [3:0] reset_ = 4'd0;
  localparam logic [3:0] active_ = 4'd1;
  localparam logic [3:0] retrain_ = 4'd2;
  localparam int LPIF_DATA_W = 512;
  typedef enum logic [1:0] {WAIT_ACTIVE, FORWARD, HOLD, FLUSH} txState_e;
  function automatic int entryWidth(input int dataW);
    return dataW + 5 * (dataW / 8);
  endfunction
endpackage

// File: rtl/lpif_fifo_mem.sv
// lpif_fifo_mem: DEPTH x WIDTH register array, one write port and an asynchronous read port
module lpif_fifo_mem #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  // Storage is data-only, so it carries no reset
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/lpif_tx_stage.sv
// lpif_tx_stage: show-ahead FIFO feeding the LPIF transmit port, gated on link state
module lpif_tx_stage
  import pcie_lpif_pkg::*;
#(
  parameter int         DATA_W     = LPIF_DATA_W,
  parameter int         DEPTH      = 8,
  parameter logic [3:0] ACTIVE_STS = active_
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dl_wr_en,
  output logic                     dl_wr_rdy,
  input  logic [DATA_W-1:0]        dl_data,
  input  logic [DATA_W/8-1:0]      dl_valid,
  input  logic [DATA_W/8-1:0]      dl_tlpstart,
  input  logic [DATA_W/8-1:0]      dl_tlpend,
  input  logic [DATA_W/8-1:0]      dl_dlpstart,
  input  logic [DATA_W/8-1:0]      dl_dlpend,
  input  logic                     flush_req,
  input  logic [3:0]               pl_state_sts,
  input  logic                     linkUp,
  input  logic                     pl_trdy,
  output logic                     lp_irdy,
  output logic [DATA_W-1:0]        lp_data,
  output logic [DATA_W/8-1:0]      lp_valid,
  output logic [DATA_W/8-1:0]      lp_tlpstart,
  output logic [DATA_W/8-1:0]      lp_tlpend,
  output logic [DATA_W/8-1:0]      lp_dlpstart,
  output logic [DATA_W/8-1:0]      lp_dlpend,
  output logic [$clog2(DEPTH):0]   occupancy,
  output logic [15:0]              drop_cnt
);
  localparam int BYTES = DATA_W / 8;
  localparam int ENTRY_W = entryWidth(DATA_W);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  txState_e state;
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [CNT_W-1:0] count;
  logic linkUpQ, isActive, flushTrig, irdy, wrFire, rdFire;
  logic [ENTRY_W-1:0] wrEntry, headEntry, outEntry;
  logic [16:0] dropSum;
  assign isActive = pl_state_sts == ACTIVE_STS;
  assign flushTrig = (linkUpQ && !linkUp) || flush_req;
  assign dl_wr_rdy = count != CNT_W'(DEPTH) && state != FLUSH && !flushTrig;
  assign irdy = state == FORWARD && count != '0 && isActive && !flushTrig;
  assign wrFire = dl_wr_en && dl_wr_rdy;
  assign rdFire = irdy && pl_trdy;
  assign wrEntry = {dl_data, dl_valid, dl_tlpstart, dl_tlpend, dl_dlpstart, dl_dlpend};
  assign outEntry = irdy ? headEntry : '0;
  assign {lp_data, lp_valid, lp_tlpstart, lp_tlpend, lp_dlpstart, lp_dlpend} = outEntry;
  assign lp_irdy = irdy;
  assign occupancy = count;
  assign dropSum = {1'b0, drop_cnt} + 17'(count);
  lpif_fifo_mem #(.DEPTH(DEPTH), .WIDTH(ENTRY_W)) u_mem (
    .clk(clk),
    .we(wrFire),
    .waddr(wrPtr),
    .wdata(wrEntry),
    .raddr(rdPtr),
    .rdata(headEntry)
  );
  // Link-state FSM, pointer/count bookkeeping and flush drop accounting
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= WAIT_ACTIVE;
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      drop_cnt <= '0;
      linkUpQ <= 1'b0;
    end else begin
      linkUpQ <= linkUp;
      if (state == FLUSH) begin
        wrPtr <= '0;
        rdPtr <= '0;
        count <= '0;
        drop_cnt <= dropSum[16] ? 16'hFFFF : dropSum[15:0];
      end else begin
        if (wrFire) wrPtr <= wrPtr + 1'b1;
        if (rdFire) rdPtr <= rdPtr + 1'b1;
        count <= count + CNT_W'(wrFire) - CNT_W'(rdFire);
      end
      state <= flushTrig ? FLUSH :
               state == FLUSH ? WAIT_ACTIVE :
               state == WAIT_ACTIVE && linkUp && isActive ? FORWARD :
               state == FORWARD && linkUp && !isActive ? HOLD :
               state == HOLD && isActive ? FORWARD : state;
    end
endmodule

// File: tb/tb_lpif_tx_stage.sv
// tb_lpif_tx_stage: scoreboard bench for the LPIF transmit stage
module tb_lpif_tx_stage;
  localparam int DW = 64;
  localparam int BY = DW / 8;
  localparam int EW = DW + 5 * BY;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic dl_wr_en = 1'b0, dl_wr_rdy, flush_req = 1'b0, linkUp = 1'b0, pl_trdy = 1'b0, lp_irdy;
  logic [DW-1:0] dl_data = '0, lp_data;
  logic [BY-1:0] dl_valid = '0, dl_tlpstart = '0, dl_tlpend = '0, dl_dlpstart = '0, dl_dlpend = '0;
  logic [BY-1:0] lp_valid, lp_tlpstart, lp_tlpend, lp_dlpstart, lp_dlpend;
  logic [3:0] pl_state_sts = 4'd0;
  logic [$clog2(DEPTH):0] occupancy;
  logic [15:0] drop_cnt;
  logic [EW-1:0] obsEntry, drvEntry;
  logic [EW-1:0] sbQ[$];
  int checks = 0;
  int errors = 0;
  lpif_tx_stage #(.DATA_W(DW), .DEPTH(DEPTH), .ACTIVE_STS(4'd1)) dut (
    .clk(clk), .reset(reset),
    .dl_wr_en(dl_wr_en), .dl_wr_rdy(dl_wr_rdy), .dl_data(dl_data), .dl_valid(dl_valid),
    .dl_tlpstart(dl_tlpstart), .dl_tlpend(dl_tlpend), .dl_dlpstart(dl_dlpstart), .dl_dlpend(dl_dlpend),
    .flush_req(flush_req), .pl_state_sts(pl_state_sts), .linkUp(linkUp), .pl_trdy(pl_trdy),
    .lp_irdy(lp_irdy), .lp_data(lp_data), .lp_valid(lp_valid), .lp_tlpstart(lp_tlpstart),
    .lp_tlpend(lp_tlpend), .lp_dlpstart(lp_dlpstart), .lp_dlpend(lp_dlpend),
    .occupancy(occupancy), .drop_cnt(drop_cnt)
  );
  always #5 clk = ~clk;
  assign obsEntry = {lp_data, lp_valid, lp_tlpstart, lp_tlpend, lp_dlpstart, lp_dlpend};
  assign drvEntry = {dl_data, dl_valid, dl_tlpstart, dl_tlpend, dl_dlpstart, dl_dlpend};
  task automatic chk(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  function automatic logic [EW-1:0] mkEntry(input int n);
    logic [7:0] b;
    b = 8'(n);
    return {DW'(n), 8'hFF, b, ~b, b ^ 8'h5A, 8'h80 >> (n % 8)};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wrBeat(input int n);
    dl_wr_en = 1'b1;
    {dl_data, dl_valid, dl_tlpstart, dl_tlpend, dl_dlpstart, dl_dlpend} = mkEntry(n);
  endtask
  task automatic idle;
    dl_wr_en = 1'b0;
  endtask
  task automatic wrBurst(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      wrBeat(first + i);
      tick;
    end
    idle;
  endtask
  // Scoreboard: pop on every PHY transfer, push on every accepted write
  always @(negedge clk) begin
    if (!reset) begin
      if (lp_irdy && pl_trdy) begin
        if (sbQ.size() == 0) chk("unexpected_beat", obsEntry, '0);
        else chk("beat", obsEntry, sbQ.pop_front());
      end
      if (!lp_irdy) chk("idle_bus_zero", obsEntry, '0);
      if (dl_wr_en && dl_wr_rdy) sbQ.push_back(drvEntry);
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end
  initial begin
    #1 reset = 1'b1;
    tick;
    tick;
    chk("rst_irdy", EW'(lp_irdy), EW'(0));
    chk("rst_rdy", EW'(dl_wr_rdy), EW'(1));
    chk("rst_occ", EW'(occupancy), EW'(0));
    chk("rst_drop", EW'(drop_cnt), EW'(0));
    chk("rst_bus", obsEntry, '0);
    reset = 1'b0;
    linkUp = 1'b1;
    pl_state_sts = 4'd1;
    pl_trdy = 1'b1;
    tick;
    wrBeat(1);
    #1 chk("t1_no_bypass", EW'(lp_irdy), EW'(0));
    tick;
    chk("t1_irdy_next", EW'(lp_irdy), EW'(1));
    wrBeat(2);
    tick;
    wrBeat(3);
    tick;
    idle;
    tick;
    tick;
    chk("t1_occ0", EW'(occupancy), EW'(0));
    chk("t1_sb_empty", EW'(sbQ.size()), EW'(0));
    pl_trdy = 1'b0;
    wrBurst(4, 8);
    chk("t2_occ8", EW'(occupancy), EW'(8));
    chk("t2_full_rdy", EW'(dl_wr_rdy), EW'(0));
    wrBeat(12);
    tick;
    idle;
    chk("t2_refused", EW'(occupancy), EW'(8));
    pl_trdy = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("t2_drain_occ", EW'(occupancy), EW'(8 - i));
      tick;
    end
    chk("t2_occ0", EW'(occupancy), EW'(0));
    chk("t2_sb_empty", EW'(sbQ.size()), EW'(0));
    pl_trdy = 1'b0;
    wrBurst(20, 4);
    pl_trdy = 1'b1;
    tick;
    pl_state_sts = 4'd2;
    #1 chk("t3_irdy_drop", EW'(lp_irdy), EW'(0));
    chk("t3_occ_kept", EW'(occupancy), EW'(3));
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("t3_hold_occ", EW'(occupancy), EW'(3));
      chk("t3_hold_irdy", EW'(lp_irdy), EW'(0));
    end
    pl_state_sts = 4'd1;
    tick;
    tick;
    tick;
    tick;
    chk("t3_occ0", EW'(occupancy), EW'(0));
    chk("t3_sb_empty", EW'(sbQ.size()), EW'(0));
    pl_trdy = 1'b0;
    wrBurst(30, 5);
    chk("t4_occ5", EW'(occupancy), EW'(5));
    linkUp = 1'b0;
    pl_trdy = 1'b1;
    sbQ.delete();
    wrBeat(99);
    #1 chk("t4_trig_irdy", EW'(lp_irdy), EW'(0));
    chk("t4_trig_rdy", EW'(dl_wr_rdy), EW'(0));
    tick;
    idle;
    chk("t4_flush_rdy", EW'(dl_wr_rdy), EW'(0));
    chk("t4_flush_irdy", EW'(lp_irdy), EW'(0));
    tick;
    chk("t4_occ0", EW'(occupancy), EW'(0));
    chk("t4_drop5", EW'(drop_cnt), EW'(5));
    chk("t4_rdy_back", EW'(dl_wr_rdy), EW'(1));
    tick;
    chk("t4_wait_irdy", EW'(lp_irdy), EW'(0));
    linkUp = 1'b1;
    pl_state_sts = 4'd1;
    tick;
    pl_trdy = 1'b0;
    wrBurst(60, 2);
    flush_req = 1'b1;
    sbQ.delete();
    #1 chk("fr_trig_irdy", EW'(lp_irdy), EW'(0));
    tick;
    flush_req = 1'b0;
    tick;
    chk("fr_occ0", EW'(occupancy), EW'(0));
    chk("fr_drop7", EW'(drop_cnt), EW'(7));
    tick;
    wrBurst(40, 8);
    chk("t5_occ8", EW'(occupancy), EW'(8));
    wrBeat(48);
    pl_trdy = 1'b1;
    tick;
    idle;
    chk("t5_full_rw", EW'(occupancy), EW'(7));
    tick;
    tick;
    tick;
    chk("t5_occ4", EW'(occupancy), EW'(4));
    wrBeat(49);
    tick;
    idle;
    chk("t5_rw_occ4", EW'(occupancy), EW'(4));
    repeat (4) tick;
    chk("t5_occ0", EW'(occupancy), EW'(0));
    chk("t5_sb_empty", EW'(sbQ.size()), EW'(0));
    pl_trdy = 1'b0;
    wrBurst(70, 6);
    chk("t6_irdy", EW'(lp_irdy), EW'(1));
    chk("t6_drop_pre", EW'(drop_cnt), EW'(7));
    #2 reset = 1'b1;
    #1 chk("t6_irdy0", EW'(lp_irdy), EW'(0));
    chk("t6_bus0", obsEntry, '0);
    chk("t6_occ0", EW'(occupancy), EW'(0));
    chk("t6_rdy1", EW'(dl_wr_rdy), EW'(1));
    chk("t6_drop0", EW'(drop_cnt), EW'(0));
    sbQ.delete();
    tick;
    tick;
    reset = 1'b0;
    tick;
    chk("t6_post_rdy", EW'(dl_wr_rdy), EW'(1));
    chk("t6_post_drop", EW'(drop_cnt), EW'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
